// File: rtl/acondicionador_temp.sv
// -----------------------------------------------------------------------------
// acondicionador_temp
//
// Conditions raw temperature-sensor ADC samples for the temperature-state FSM.
//   Stage 1: subtract the raw-code offset and saturate to the 11-bit signed range.
//   Stage 2: optionally apply a 4-tap moving average. Then register the result
//            as temp_registrado and update the out-of-range persistence count
//            using that new value.
// A sensor-silence watchdog raises sensor_falla after TIMEOUT cycles with no
// valid sample.
//
// Optional feature macro: PROMEDIO_EN
//   defined   -> 4-tap moving average between stage 1 and stage 2.
//   undefined -> stage 2 passes the converted sample through unchanged.
// The latency is two cycles in both builds.
//
// Ports
//   clk                  in   1        system clock, rising edge
//   rst                  in   1        synchronous reset, active-high
//   muestra_raw          in   12       unsigned ADC code, qualified by muestra_valida
//   muestra_valida       in   1        strobe: muestra_raw is valid this cycle
//   temp_registrado      out  11 (s)   conditioned temperature, two's complement
//   contador_fuera_rango out  3        consecutive out-of-range samples, saturates at 7
//   dato_valido          out  1        1-cycle pulse when the outputs above update
//   sensor_falla         out  1        watchdog flag, sticky until the next valid sample
// -----------------------------------------------------------------------------
module acondicionador_temp #(
  parameter int OFFSET    = 400,
  parameter int TEMP_BAJO = 180,
  parameter int TEMP_ALTO = 250,
  parameter int TIMEOUT   = 1000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [11:0]        muestra_raw,
  input  logic               muestra_valida,
  output logic signed [10:0] temp_registrado,
  output logic [2:0]         contador_fuera_rango,
  output logic               dato_valido,
  output logic               sensor_falla
);

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);
  localparam logic [WD_W-1:0] WD_PRE = WD_W'(TIMEOUT - 1);

  localparam logic signed [12:0] OFFSET_S = 13'(OFFSET);
  localparam logic signed [10:0] BAJO_S   = 11'(TEMP_BAJO);
  localparam logic signed [10:0] ALTO_S   = 11'(TEMP_ALTO);

  // ---------------------------------------------------------------------------
  // Stage 1: offset removal and saturation
  // ---------------------------------------------------------------------------
  logic signed [12:0] diff;
  logic signed [10:0] conv_next;
  logic signed [10:0] conv_reg;
  logic               v1_reg;

  // The raw code is zero-extended to 13 bits. With a 12-bit code the
  // difference always fits in 13-bit signed.
  assign diff = $signed({1'b0, muestra_raw}) - OFFSET_S;

  always_comb begin
    conv_next = diff[10:0];
    if (diff > 13'sd1023) begin
      conv_next = 11'sh3FF;
    end else if (diff < -13'sd1024) begin
      conv_next = 11'sh400;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      conv_reg <= '0;
      v1_reg   <= 1'b0;
    end else begin
      v1_reg <= muestra_valida;
      if (muestra_valida) begin
        conv_reg <= conv_next;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Optional moving-average filter between the stages
  // ---------------------------------------------------------------------------
  logic signed [10:0] filt;

`ifdef PROMEDIO_EN
  logic signed [10:0] prom_buf_reg [4];
  logic signed [12:0] sum_reg;
  logic signed [12:0] sum_next;
  logic signed [12:0] conv_ext;
  logic signed [12:0] oldest_ext;
  logic               primed_reg;

  assign conv_ext   = {{2{conv_reg[10]}}, conv_reg};
  assign oldest_ext = {{2{prom_buf_reg[3][10]}}, prom_buf_reg[3]};

  // When the buffer is unprimed, the first sample fills every tap. The sum is
  // then simply 4x that sample.
  always_comb begin
    sum_next = {conv_reg, 2'b00};
    if (primed_reg) begin
      sum_next = sum_reg - oldest_ext + conv_ext;
    end
  end

  // Taking the top bits is an arithmetic shift right by 2, which floors toward -inf.
  assign filt = sum_next[12:2];

  always_ff @(posedge clk) begin
    if (rst) begin
      primed_reg <= 1'b0;
      sum_reg    <= '0;
      for (int i = 0; i < 4; i++) begin
        prom_buf_reg[i] <= '0;
      end
    end else if (v1_reg) begin
      primed_reg      <= 1'b1;
      sum_reg         <= sum_next;
      prom_buf_reg[0] <= conv_reg;
      for (int i = 1; i < 4; i++) begin
        prom_buf_reg[i] <= primed_reg ? prom_buf_reg[i-1] : conv_reg;
      end
    end
  end
`else
  assign filt = conv_reg;
`endif

  // ---------------------------------------------------------------------------
  // Stage 2: output register and persistence counter
  // ---------------------------------------------------------------------------
  logic       fuera_rango;
  logic [2:0] contador_next;

  assign fuera_rango = (filt < BAJO_S) || (filt > ALTO_S);

  always_comb begin
    contador_next = 3'd0;
    if (fuera_rango) begin
      contador_next = (contador_fuera_rango == 3'd7) ? 3'd7
                                                    : contador_fuera_rango + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      temp_registrado      <= '0;
      contador_fuera_rango <= '0;
      dato_valido          <= 1'b0;
    end else begin
      dato_valido <= v1_reg;
      if (v1_reg) begin
        temp_registrado      <= filt;
        contador_fuera_rango <= contador_next;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sensor-silence watchdog
  // ---------------------------------------------------------------------------
  logic [WD_W-1:0] wd_cnt_reg;

  // The flag is set on the same edge that the count reaches TIMEOUT. A strobe
  // on that edge takes priority and clears both the count and the flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt_reg   <= '0;
      sensor_falla <= 1'b0;
    end else if (muestra_valida) begin
      wd_cnt_reg   <= '0;
      sensor_falla <= 1'b0;
    end else begin
      if (wd_cnt_reg != WD_MAX) begin
        wd_cnt_reg <= wd_cnt_reg + 1'b1;
      end
      if (wd_cnt_reg >= WD_PRE) begin
        sensor_falla <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_acondicionador_temp.sv
// -----------------------------------------------------------------------------
// tb_acondicionador_temp
//
// Directed stimulus for acondicionador_temp. A behavioural model tracks which
// samples are in flight and when each one is due. It computes the expected
// outputs arithmetically. A negedge process compares every DUT output with the
// model on every cycle. Literal hand-computed values pin the model at key points.
// -----------------------------------------------------------------------------
module tb_acondicionador_temp;

  localparam int OFFSET    = 400;
  localparam int TEMP_BAJO = 180;
  localparam int TEMP_ALTO = 250;
  localparam int TIMEOUT   = 20;

  logic               clk;
  logic               rst;
  logic [11:0]        muestra_raw;
  logic               muestra_valida;
  logic signed [10:0] temp_registrado;
  logic [2:0]         contador_fuera_rango;
  logic               dato_valido;
  logic               sensor_falla;

  acondicionador_temp #(
    .OFFSET   (OFFSET),
    .TEMP_BAJO(TEMP_BAJO),
    .TEMP_ALTO(TEMP_ALTO),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .muestra_raw         (muestra_raw),
    .muestra_valida      (muestra_valida),
    .temp_registrado     (temp_registrado),
    .contador_fuera_rango(contador_fuera_rango),
    .dato_valido         (dato_valido),
    .sensor_falla        (sensor_falla)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  bit checking = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  typedef struct {
    int raw;
    int due;
  } pend_t;

  pend_t q[$];
  pend_t p;
  int    edge_n  = 0;
  int    m_temp  = 0;
  int    m_cnt   = 0;
  int    m_dv    = 0;
  int    m_falla = 0;
  int    m_idle  = 0;
  int    hist[4];
  bit    primed  = 1'b0;

  task apply_sample(input int raw);
    int t;
    int s;
    t = raw - OFFSET;
    if (t > 1023)  t = 1023;
    if (t < -1024) t = -1024;
`ifdef PROMEDIO_EN
    if (!primed) begin
      for (int i = 0; i < 4; i++) hist[i] = t;
      primed = 1'b1;
    end else begin
      for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = t;
    end
    s = hist[0] + hist[1] + hist[2] + hist[3];
    // Floor division by 4, rounding toward -inf.
    t = (s >= 0) ? s / 4 : -((-s + 3) / 4);
`else
    s = 0;
`endif
    m_temp = t;
    if (t < TEMP_BAJO || t > TEMP_ALTO) begin
      m_cnt = (m_cnt >= 7) ? 7 : m_cnt + 1;
    end else begin
      m_cnt = 0;
    end
    m_dv = 1;
  endtask

  always @(posedge clk) begin
    edge_n++;
    m_dv = 0;
    if (rst) begin
      q.delete();
      m_temp  = 0;
      m_cnt   = 0;
      m_falla = 0;
      m_idle  = 0;
      primed  = 1'b0;
    end else begin
      if (q.size() > 0 && q[0].due == edge_n) begin
        p = q.pop_front();
        apply_sample(p.raw);
      end
      if (muestra_valida) begin
        q.push_back('{int'(muestra_raw), edge_n + 1});
        m_idle  = 0;
        m_falla = 0;
      end else begin
        m_idle++;
        if (m_idle >= TIMEOUT) m_falla = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      chk("temp_registrado", int'(temp_registrado), m_temp);
      chk("contador_fuera_rango", int'(contador_fuera_rango), m_cnt);
      chk("dato_valido", int'(dato_valido), m_dv);
      chk("sensor_falla", int'(sensor_falla), m_falla);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic send(input int raw);
    @(posedge clk); #1;
    muestra_valida = 1'b1;
    muestra_raw    = 12'(raw);
    @(posedge clk); #1;
    muestra_valida = 1'b0;
    $display("sample raw=%0d sent", raw);
  endtask

  // Advances to just after the edge on which the last sent sample appears.
  task automatic wait_out();
    @(posedge clk); #1;
    $display("out temp=%0d cnt=%0d dv=%0d falla=%0d",
             temp_registrado, contador_fuera_rango, dato_valido, sensor_falla);
  endtask

  task automatic burst(input int raw, input int n);
    @(posedge clk); #1;
    muestra_valida = 1'b1;
    muestra_raw    = 12'(raw);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
    muestra_valida = 1'b0;
    $display("burst raw=%0d x%0d sent", raw, n);
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    rst            = 1'b1;
    muestra_valida = 1'b0;
    muestra_raw    = '0;
    repeat (2) @(posedge clk);
    #1;
    checking = 1'b1;
    chk("reset temp", int'(temp_registrado), 0);
    chk("reset cnt", int'(contador_fuera_rango), 0);
    chk("reset dv", int'(dato_valido), 0);
    chk("reset falla", int'(sensor_falla), 0);
    rst = 1'b0;

    // Pass-through: raw 600 maps to 200 (it primes the filter when enabled).
    send(600);
    wait_out();
    chk("lit 600 temp", int'(temp_registrado), 200);
    chk("lit 600 dv", int'(dato_valido), 1);
    chk("lit 600 cnt", int'(contador_fuera_rango), 0);

    // Persistence: nine back-to-back out-of-range samples.
    burst(500, 9);
    wait_out();
    chk("lit persist cnt", int'(contador_fuera_rango), 7);
    chk("lit persist temp", int'(temp_registrado), 100);
    send(600);
    wait_out();
`ifndef PROMEDIO_EN
    chk("lit persist clear", int'(contador_fuera_rango), 0);

    // Boundaries, all sent back to back.
    send(580); wait_out();
    chk("lit bound 180", int'(contador_fuera_rango), 0);
    send(579); wait_out();
    chk("lit bound 179", int'(contador_fuera_rango), 1);
    send(651); wait_out();
    chk("lit bound 251", int'(contador_fuera_rango), 2);
    send(650); wait_out();
    chk("lit bound 250", int'(contador_fuera_rango), 0);
`endif

    // Watchdog: silence for longer than TIMEOUT.
    repeat (TIMEOUT + 3) @(posedge clk);
    #1;
    chk("lit wd set", int'(sensor_falla), 1);
    send(600);
    chk("lit wd clear", int'(sensor_falla), 0);
    // The next strobe lands exactly on the edge where the count would reach TIMEOUT.
    repeat (TIMEOUT - 2) @(posedge clk);
    send(600);
    chk("lit wd race", int'(sensor_falla), 0);

    // Reset mid-stream with samples in flight.
    @(posedge clk); #1;
    muestra_valida = 1'b1;
    muestra_raw    = 12'd700;
    @(posedge clk); #1;
    muestra_raw    = 12'd710;
    @(posedge clk); #1;
    rst            = 1'b1;
    muestra_raw    = 12'd720;
    repeat (2) @(posedge clk);
    #1;
    rst            = 1'b0;
    muestra_valida = 1'b0;
    chk("lit rst temp", int'(temp_registrado), 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("lit rst no dv", int'(dato_valido), 0);
    end

`ifdef PROMEDIO_EN
    send(600); wait_out();
    chk("lit avg 0", int'(temp_registrado), 200);
    send(680); wait_out();
    chk("lit avg 1", int'(temp_registrado), 220);
    send(680); wait_out();
    chk("lit avg 2", int'(temp_registrado), 240);
    send(680); wait_out();
    chk("lit avg 3", int'(temp_registrado), 260);
    send(680); wait_out();
    chk("lit avg 4", int'(temp_registrado), 280);
`endif

    // Saturation.
    send(0); wait_out();
`ifndef PROMEDIO_EN
    chk("lit sat low", int'(temp_registrado), -400);
`endif
    send(4095); wait_out();
`ifndef PROMEDIO_EN
    chk("lit sat high", int'(temp_registrado), 1023);
`endif

    repeat (4) @(posedge clk);
    #1;
    checking = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
